sys_cmd_framer: RTL and testbench

- Host-side counterpart of the system controller. It accepts one command at a time (register write, register read, ALU with operands, ALU without operands) and serialises it into the UART byte frame the controller decodes.
- Bytes go out through a UART TX byte interface using a valid/busy handshake.
- For read and ALU commands it then collects the response bytes from a UART RX byte interface and reports the result, or a timeout.
- Used in the host bridge and as the stimulus engine for system-level benches.

---
 rtl/sys_cmd_framer.sv | 199 +++++++++++++++++++
 tb/tb_sys_cmd_framer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_framer.sv
// Host-side command framer: serialises one command into the controller's UART frame
// and collects the 1- or 2-byte response, reporting the result or a timeout.
//
// Ports:
//   clk, rst (async active-low)
//   cmd_valid/cmd_ready, cmd_type, cmd_addr, cmd_data, cmd_op_a, cmd_op_b, cmd_fun : command in
//   tx_data/tx_valid, tx_busy : UART TX byte interface
//   rx_data/rx_valid : UART RX byte interface
//   rsp_data/rsp_valid/rsp_timeout : response out
//   busy : high whenever not idle
module sys_cmd_framer #(
   parameter int DATA_WIDTH  = 8,
   parameter int REG_ADDR    = 4,
   parameter int RSP_TIMEOUT = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_type,
   input  logic [REG_ADDR-1:0]       cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_data,
   input  logic [DATA_WIDTH-1:0]     cmd_op_a,
   input  logic [DATA_WIDTH-1:0]     cmd_op_b,
   input  logic [3:0]                cmd_fun,
   output logic [DATA_WIDTH-1:0]     tx_data,
   output logic                      tx_valid,
   input  logic                      tx_busy,
   input  logic [DATA_WIDTH-1:0]     rx_data,
   input  logic                      rx_valid,
   output logic [2*DATA_WIDTH-1:0]   rsp_data,
   output logic                      rsp_valid,
   output logic                      rsp_timeout,
   output logic                      busy
);

   localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(RSP_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEND    = 3'd1;
   localparam logic [2:0] S_WAIT_HI = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_RSP     = 3'd4;

   localparam logic [1:0] T_WR  = 2'd0;
   localparam logic [1:0] T_RD  = 2'd1;
   localparam logic [1:0] T_OP  = 2'd2;
   localparam logic [1:0] T_NOP = 2'd3;

   logic [2:0]            state;
   logic [1:0]            c_type;
   logic [REG_ADDR-1:0]   c_addr;
   logic [DATA_WIDTH-1:0] c_data;
   logic [DATA_WIDTH-1:0] c_op_a;
   logic [DATA_WIDTH-1:0] c_op_b;
   logic [3:0]            c_fun;
   logic [1:0]            idx;
   logic [1:0]            last_idx;
   logic [DATA_WIDTH-1:0] nbyte;
   logic                  rx_got;
   logic [DATA_WIDTH-1:0] rx_lo;
   logic [TW-1:0]         tcnt;
   logic                  need_two;
   logic                  has_rsp;

   assign busy      = (state != S_IDLE);
   assign cmd_ready = ~busy;
   // ALU commands (types 2 and 3) return two bytes, REG_RD one, REG_WR none
   assign need_two  = c_type[1];
   assign has_rsp   = (c_type != T_WR);

   always_comb begin
      nbyte    = '0;
      last_idx = 2'd1;
      unique case (c_type)
         T_WR: begin
            last_idx = 2'd2;
            case (idx)
               2'd0:    nbyte = DATA_WIDTH'(8'hAA);
               2'd1:    nbyte = DATA_WIDTH'(c_addr);
               default: nbyte = c_data;
            endcase
         end
         T_RD: begin
            last_idx = 2'd1;
            case (idx)
               2'd0:    nbyte = DATA_WIDTH'(8'hBB);
               default: nbyte = DATA_WIDTH'(c_addr);
            endcase
         end
         T_OP: begin
            last_idx = 2'd3;
            case (idx)
               2'd0:    nbyte = DATA_WIDTH'(8'hCC);
               2'd1:    nbyte = c_op_a;
               2'd2:    nbyte = c_op_b;
               default: nbyte = DATA_WIDTH'(c_fun);
            endcase
         end
         T_NOP: begin
            last_idx = 2'd1;
            case (idx)
               2'd0:    nbyte = DATA_WIDTH'(8'hDD);
               default: nbyte = DATA_WIDTH'(c_fun);
            endcase
         end
         default: begin
            nbyte    = '0;
            last_idx = 2'd1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         c_type      <= '0;
         c_addr      <= '0;
         c_data      <= '0;
         c_op_a      <= '0;
         c_op_b      <= '0;
         c_fun       <= '0;
         idx         <= '0;
         rx_got      <= 1'b0;
         rx_lo       <= '0;
         tcnt        <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         rsp_data    <= '0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         tx_valid    <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  c_type <= cmd_type;
                  c_addr <= cmd_addr;
                  c_data <= cmd_data;
                  c_op_a <= cmd_op_a;
                  c_op_b <= cmd_op_b;
                  c_fun  <= cmd_fun;
                  idx    <= '0;
                  state  <= S_SEND;
               end
            end
            S_SEND: begin
               if (!tx_busy) begin
                  tx_data  <= nbyte;
                  tx_valid <= 1'b1;
                  state    <= S_WAIT_HI;
               end
            end
            S_WAIT_HI: begin
               if (tx_busy) state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!tx_busy) begin
                  if (idx != last_idx) begin
                     idx   <= idx + 2'd1;
                     state <= S_SEND;
                  end else if (has_rsp) begin
                     tcnt   <= '0;
                     rx_got <= 1'b0;
                     state  <= S_RSP;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_RSP: begin
               // a byte arriving on the timeout cycle still counts
               if (rx_valid) begin
                  tcnt <= '0;
                  if (!need_two || rx_got) begin
                     rsp_data  <= need_two ? {rx_data, rx_lo}
                                           : {{DATA_WIDTH{1'b0}}, rx_data};
                     rsp_valid <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     rx_lo  <= rx_data;
                     rx_got <= 1'b1;
                  end
               end else if (tcnt == TMAX) begin
                  rsp_timeout <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_cmd_framer.sv
// Bench for sys_cmd_framer: vector table of commands, TX busy model,
// scoreboard queues for TX bytes and responses.
module tb_sys_cmd_framer;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int TMO = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [1:0]      cmd_type;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_data;
   logic [DW-1:0]   cmd_op_a;
   logic [DW-1:0]   cmd_op_b;
   logic [3:0]      cmd_fun;
   logic [DW-1:0]   tx_data;
   logic            tx_valid;
   logic            tx_busy;
   logic [DW-1:0]   rx_data;
   logic            rx_valid;
   logic [2*DW-1:0] rsp_data;
   logic            rsp_valid;
   logic            rsp_timeout;
   logic            busy;

   sys_cmd_framer #(
      .DATA_WIDTH (DW),
      .REG_ADDR   (AW),
      .RSP_TIMEOUT(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_type   (cmd_type),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .cmd_op_a   (cmd_op_a),
      .cmd_op_b   (cmd_op_b),
      .cmd_fun    (cmd_fun),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_busy    (tx_busy),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rsp_data   (rsp_data),
      .rsp_valid  (rsp_valid),
      .rsp_timeout(rsp_timeout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // UART TX model: busy for tx_len cycles starting the cycle after a strobe
   int   tx_len    = 10;
   int   tx_cnt    = 0;
   logic hold_busy = 1'b0;

   always @(posedge clk) begin
      if (!rst)           tx_cnt <= 0;
      else if (tx_valid)  tx_cnt <= tx_len;
      else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
   end

   assign tx_busy = hold_busy || (tx_cnt != 0);

   typedef struct {
      logic [1:0]  ty;
      logic [3:0]  addr;
      logic [7:0]  data;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  fun;
      int          tl;
      int          nb;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [7:0]  b3;
      int          nrx;
      logic [7:0]  r0;
      logic [7:0]  r1;
      int          rk;
      logic [15:0] rsp;
   } vec_t;

   typedef struct {
      int          kind;
      logic [15:0] d;
   } rsp_t;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_tx[$];
   rsp_t        exp_rsp[$];
   logic [15:0] model_rsp = '0;
   logic        tmo_flag = 1'b0;
   logic        prev_txv = 1'b0;
   int          tx_strobes = 0;
   vec_t        vecs[5];
   vec_t        vs;

   task automatic cmp(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected or bound expired", name);
   endtask

   // advance to the next falling edge and check whatever the DUT produced
   task automatic step();
      rsp_t r;
      @(negedge clk);
      if (tx_valid === 1'b1) begin
         tx_strobes++;
         cmp("tx_busy_at_strobe", tx_busy, 0);
         cmp("tx_valid_width", prev_txv, 0);
         if (exp_tx.size() == 0) fail_now("tx_unexpected");
         else cmp("tx_byte", tx_data, exp_tx.pop_front());
      end
      prev_txv = tx_valid;
      if (rsp_valid || rsp_timeout) begin
         if (rsp_timeout) tmo_flag = 1'b1;
         if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
         else begin
            r = exp_rsp.pop_front();
            cmp("rsp_kind", {rsp_timeout, rsp_valid},
                (r.kind == 2) ? 2 : 1);
            cmp("rsp_data", rsp_data, r.d);
         end
      end
      cmp("ready_vs_busy", cmd_ready, !busy);
   endtask

   task automatic send_cmd(input vec_t v);
      int n;
      n = 0;
      while (!cmd_ready && n < 500) begin
         step();
         n++;
      end
      if (!cmd_ready) fail_now("cmd_ready_wait");
      tx_len    = v.tl;
      cmd_type  = v.ty;
      cmd_addr  = v.addr;
      cmd_data  = v.data;
      cmd_op_a  = v.a;
      cmd_op_b  = v.b;
      cmd_fun   = v.fun;
      exp_tx.push_back(v.b0);
      exp_tx.push_back(v.b1);
      if (v.nb > 2) exp_tx.push_back(v.b2);
      if (v.nb > 3) exp_tx.push_back(v.b3);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cmp("busy_after_accept", busy, 1);
   endtask

   task automatic wait_tx_done();
      int n;
      n = 0;
      while (exp_tx.size() != 0 && n < 1000) begin
         step();
         n++;
      end
      if (exp_tx.size() != 0) fail_now("tx_frame_bound");
      n = 0;
      while (!tx_busy && n < 20) begin
         step();
         n++;
      end
      n = 0;
      while (tx_busy && n < 100) begin
         step();
         n++;
      end
      if (tx_busy) fail_now("tx_busy_fall_bound");
      step();
   endtask

   task automatic run_vec(input vec_t v, input bit stray);
      rsp_t r;
      int   cyc;
      tmo_flag = 1'b0;
      if (v.rk == 1) begin
         r.kind = 1;
         r.d = v.rsp;
         model_rsp = v.rsp;
         exp_rsp.push_back(r);
      end else if (v.rk == 2) begin
         r.kind = 2;
         r.d = model_rsp;
         exp_rsp.push_back(r);
      end
      if (stray) begin
         hold_busy = 1'b1;
         rx_data = 8'h99;
         rx_valid = 1'b1;
         step();
         rx_valid = 1'b0;
      end
      send_cmd(v);
      if (stray) begin
         rx_data = 8'hEE;
         rx_valid = 1'b1;
         step();
         rx_valid = 1'b0;
         for (int i = 0; i < 4; i++) begin
            step();
            cmp("no_strobe_while_busy", tx_valid, 0);
         end
         hold_busy = 1'b0;
      end
      wait_tx_done();
      cmp("cmd_ready_after_frame", cmd_ready, (v.ty == 2'd0));
      for (int i = 0; i < v.nrx; i++) begin
         rx_data = (i == 0) ? v.r0 : v.r1;
         rx_valid = 1'b1;
         step();
         rx_valid = 1'b0;
         if (i < v.nrx - 1) begin
            step();
            step();
         end
      end
      if (v.rk == 2) begin
         cyc = 0;
         while (!tmo_flag && cyc < 300) begin
            step();
            cyc++;
         end
         cmp("timeout_latency", cyc, TMO);
      end
      cyc = 0;
      while (busy && cyc < 300) begin
         step();
         cyc++;
      end
      cmp("idle_after_cmd", busy, 0);
      cmp("rsp_events_left", exp_rsp.size(), 0);
      cmp("rsp_data_hold", rsp_data, model_rsp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{ty:2'd0, addr:4'h5, data:8'h3C, a:8'h00, b:8'h00,
                  fun:4'h0, tl:10, nb:3, b0:8'hAA, b1:8'h05, b2:8'h3C,
                  b3:8'h00, nrx:0, r0:8'h00, r1:8'h00, rk:0, rsp:16'h0};
      vecs[1] = '{ty:2'd1, addr:4'h2, data:8'h00, a:8'h00, b:8'h00,
                  fun:4'h0, tl:10, nb:2, b0:8'hBB, b1:8'h02, b2:8'h00,
                  b3:8'h00, nrx:1, r0:8'h7E, r1:8'h00, rk:1,
                  rsp:16'h007E};
      vecs[2] = '{ty:2'd2, addr:4'h0, data:8'h00, a:8'h12, b:8'h34,
                  fun:4'h1, tl:10, nb:4, b0:8'hCC, b1:8'h12, b2:8'h34,
                  b3:8'h01, nrx:2, r0:8'h46, r1:8'h00, rk:1,
                  rsp:16'h0046};
      vecs[3] = '{ty:2'd3, addr:4'h0, data:8'h00, a:8'h00, b:8'h00,
                  fun:4'h3, tl:10, nb:2, b0:8'hDD, b1:8'h03, b2:8'h00,
                  b3:8'h00, nrx:1, r0:8'h5A, r1:8'h00, rk:2, rsp:16'h0};
      vecs[4] = '{ty:2'd2, addr:4'hF, data:8'hFF, a:8'hA5, b:8'hC3,
                  fun:4'hF, tl:1, nb:4, b0:8'hCC, b1:8'hA5, b2:8'hC3,
                  b3:8'h0F, nrx:2, r0:8'h68, r1:8'h01, rk:1,
                  rsp:16'h0168};

      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_type  = '0;
      cmd_addr  = '0;
      cmd_data  = '0;
      cmd_op_a  = '0;
      cmd_op_b  = '0;
      cmd_fun   = '0;
      rx_data   = '0;
      rx_valid  = 1'b0;
      repeat (3) step();
      cmp("rst_cmd_ready", cmd_ready, 1);
      cmp("rst_busy", busy, 0);
      cmp("rst_tx_valid", tx_valid, 0);
      cmp("rst_tx_data", tx_data, 0);
      cmp("rst_rsp_data", rsp_data, 0);
      cmp("rst_rsp_valid", rsp_valid, 0);
      cmp("rst_rsp_timeout", rsp_timeout, 0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

      vs = '{ty:2'd1, addr:4'h3, data:8'h00, a:8'h00, b:8'h00,
             fun:4'h0, tl:6, nb:2, b0:8'hBB, b1:8'h03, b2:8'h00,
             b3:8'h00, nrx:1, r0:8'h55, r1:8'h00, rk:1, rsp:16'h0055};
      run_vec(vs, 1'b1);

      // reset while the ALU_OP frame waits for its first byte to finish
      vs = '{ty:2'd2, addr:4'h0, data:8'h00, a:8'h21, b:8'h43,
             fun:4'h2, tl:10, nb:4, b0:8'hCC, b1:8'h21, b2:8'h43,
             b3:8'h02, nrx:0, r0:8'h00, r1:8'h00, rk:0, rsp:16'h0};
      send_cmd(vs);
      for (int n = 0; n < 100 && exp_tx.size() == 4; n++) step();
      for (int n = 0; n < 20 && !tx_busy; n++) step();
      if (!tx_busy) fail_now("reach_wait_lo");
      step();
      rst = 1'b0;
      #1;
      cmp("mid_rst_tx_valid", tx_valid, 0);
      cmp("mid_rst_tx_data", tx_data, 0);
      cmp("mid_rst_busy", busy, 0);
      cmp("mid_rst_cmd_ready", cmd_ready, 1);
      cmp("mid_rst_rsp_data", rsp_data, 0);
      cmp("mid_rst_rsp_valid", rsp_valid, 0);
      cmp("mid_rst_rsp_timeout", rsp_timeout, 0);
      model_rsp = '0;
      exp_tx.delete();
      exp_rsp.delete();
      repeat (3) step();
      rst = 1'b1;
      tx_strobes = 0;
      repeat (40) step();
      cmp("tx_after_reset", tx_strobes, 0);
      cmp("idle_after_reset", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
